mem_rd_sched: RTL and testbench

Read-request scheduler for the accelerator's single memory read channel. It shares one `t_mem_tx` request port among four requesters: CPU instruction fetch, RNN weight loader, DNN weight loader and image loader. It arbitrates round-robin and keeps exactly one request outstanding. It matches the returning `t_mem_rx_status` code to the owner and signals completion or timeout back to that requester.

---
 rtl/mem_rd_sched_pkg.sv | 70 +++++++
 rtl/mem_rd_sched_rr_arbiter4.sv | 36 +++
 rtl/mem_rd_sched.sv | 152 +++++++++++++++
 tb/tb_mem_rd_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_sched_pkg.sv
// Shared data types for the memory read request path: request/status codes,
// the request-port word, requester indices and the scheduler FSM states.
package mem_rd_sched_pkg;

   localparam int NUM_MEM_REQ = 4;

   typedef logic [31:0] t_mem_addr;

   typedef enum logic [2:0] {
      MEM_RD_NONE  = 3'd0,
      MEM_RD_INSTR = 3'd1,
      MEM_RD_RNN_W = 3'd2,
      MEM_RD_DNN_W = 3'd3,
      MEM_RD_IMAGE = 3'd4
   } t_mem_rd_req_type;

   typedef enum logic [2:0] {
      MEM_RX_NONE        = 3'd0,
      MEM_RX_INSTR_VALID = 3'd1,
      MEM_RX_RNN_W_VALID = 3'd2,
      MEM_RX_DNN_W_VALID = 3'd3,
      MEM_RX_IMAGE_VALID = 3'd4
   } t_mem_rx_status;

   typedef struct packed {
      t_mem_rd_req_type req_type;
      t_mem_addr        addr;
   } t_mem_tx;

   typedef enum logic [1:0] {
      REQ_INSTR = 2'd0,
      REQ_RNN_W = 2'd1,
      REQ_DNN_W = 2'd2,
      REQ_IMAGE = 2'd3
   } t_mem_req_idx;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } t_sched_state;

   // Request type driven on the memory port for a given requester.
   function automatic t_mem_rd_req_type req_type_of(input t_mem_req_idx idx);
      case (idx)
         REQ_INSTR: req_type_of = MEM_RD_INSTR;
         REQ_RNN_W: req_type_of = MEM_RD_RNN_W;
         REQ_DNN_W: req_type_of = MEM_RD_DNN_W;
         REQ_IMAGE: req_type_of = MEM_RD_IMAGE;
         default:   req_type_of = MEM_RD_NONE;
      endcase
   endfunction

   // Status code that completes a request issued by a given requester.
   function automatic t_mem_rx_status rx_status_of(input t_mem_req_idx idx);
      case (idx)
         REQ_INSTR: rx_status_of = MEM_RX_INSTR_VALID;
         REQ_RNN_W: rx_status_of = MEM_RX_RNN_W_VALID;
         REQ_DNN_W: rx_status_of = MEM_RX_DNN_W_VALID;
         REQ_IMAGE: rx_status_of = MEM_RX_IMAGE_VALID;
         default:   rx_status_of = MEM_RX_NONE;
      endcase
   endfunction

   // One-hot vector selecting a single requester.
   function automatic logic [NUM_MEM_REQ-1:0] idx_onehot(input t_mem_req_idx idx);
      idx_onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mem_rd_sched_rr_arbiter4.sv
// Combinational four-way round-robin arbiter. The search starts at the
// requester after ptr, so the last winner has the lowest priority.
module rr_arbiter4
   import mem_rd_sched_pkg::*;
(
   input  logic [NUM_MEM_REQ-1:0] req_valid,
   input  t_mem_req_idx           ptr,
   output logic [NUM_MEM_REQ-1:0] grant,
   output t_mem_req_idx           grant_idx,
   output logic                   grant_valid
);

   logic [1:0] cand_s;

   // Pick the first valid requester at ptr+1, ptr+2, ... (mod 4).
   always_comb begin
      cand_s      = 2'b00;
      grant_valid = 1'b0;
      grant_idx   = REQ_INSTR;
      for (int off = 1; off <= NUM_MEM_REQ; off++) begin
         cand_s = 2'(int'(ptr) + off);
         if (!grant_valid && req_valid[cand_s]) begin
            grant_valid = 1'b1;
            grant_idx   = t_mem_req_idx'(cand_s);
         end else begin
            grant_valid = grant_valid;
         end
      end
      if (grant_valid) begin
         grant = idx_onehot(grant_idx);
      end else begin
         grant = 4'b0000;
      end
   end

endmodule

// File: rtl/mem_rd_sched.sv
// Read-request scheduler: shares one memory request port among four
// requesters, keeps one request outstanding and routes done/timeout back.
module mem_rd_sched
   import mem_rd_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_MEM_REQ-1:0]        req_valid,
   input  logic [NUM_MEM_REQ-1:0][31:0]  req_addr,
   output logic [NUM_MEM_REQ-1:0]        req_ready,
   output logic [NUM_MEM_REQ-1:0]        rsp_done,
   output logic [NUM_MEM_REQ-1:0]        rsp_timeout,
   output t_mem_tx                       mem_tx,
   input  t_mem_rx_status                mem_rx_status,
   output logic                          busy,
   output logic                          spurious,
   input  logic                          spurious_clr
);

   // Counter must hold 0..TIMEOUT_CYCLES inclusive.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);

   t_sched_state           state_r, state_nxt_s;
   t_mem_tx                mem_tx_r, mem_tx_nxt_s;
   t_mem_req_idx           owner_r, owner_nxt_s;
   t_mem_req_idx           ptr_r, ptr_nxt_s;
   logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
   logic [NUM_MEM_REQ-1:0] done_r, done_nxt_s;
   logic [NUM_MEM_REQ-1:0] timeout_r, timeout_nxt_s;
   logic                   spurious_r, spurious_nxt_s;
   logic                   spur_set_s;

   logic [NUM_MEM_REQ-1:0] grant_s;
   t_mem_req_idx           grant_idx_s;
   logic                   grant_valid_s;
   t_mem_rx_status         owner_status_s;

   rr_arbiter4 u_arb (
      .req_valid   (req_valid),
      .ptr         (ptr_r),
      .grant       (grant_s),
      .grant_idx   (grant_idx_s),
      .grant_valid (grant_valid_s)
   );

   assign owner_status_s = rx_status_of(owner_r);

   // Next-state, next-output and handshake decode for the IDLE/ISSUE/WAIT FSM.
   always_comb begin
      state_nxt_s   = state_r;
      mem_tx_nxt_s  = mem_tx_r;
      owner_nxt_s   = owner_r;
      ptr_nxt_s     = ptr_r;
      cnt_nxt_s     = cnt_r;
      done_nxt_s    = 4'b0000;
      timeout_nxt_s = 4'b0000;
      spur_set_s    = 1'b0;
      req_ready     = 4'b0000;
      case (state_r)
         ST_IDLE: begin
            // Nothing is outstanding, so any status is unsolicited.
            spur_set_s = (mem_rx_status != MEM_RX_NONE);
            if (grant_valid_s) begin
               req_ready             = grant_s;
               mem_tx_nxt_s.req_type = req_type_of(grant_idx_s);
               mem_tx_nxt_s.addr     = req_addr[grant_idx_s];
               owner_nxt_s           = grant_idx_s;
               ptr_nxt_s             = grant_idx_s;
               state_nxt_s           = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Memory never answers in the issue cycle.
            spur_set_s            = (mem_rx_status != MEM_RX_NONE);
            mem_tx_nxt_s.req_type = MEM_RD_NONE;
            mem_tx_nxt_s.addr     = 32'h0000_0000;
            cnt_nxt_s             = CNT_ZERO;
            state_nxt_s           = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rx_status == owner_status_s) begin
               // A match wins even in the cycle the counter hits the limit.
               done_nxt_s  = idx_onehot(owner_r);
               state_nxt_s = ST_IDLE;
            end else begin
               spur_set_s = (mem_rx_status != MEM_RX_NONE);
               if (TO_EN && (cnt_r == CNT_LIMIT)) begin
                  timeout_nxt_s = idx_onehot(owner_r);
                  state_nxt_s   = ST_IDLE;
               end else if (TO_EN) begin
                  cnt_nxt_s   = cnt_r + CNT_ONE;
                  state_nxt_s = ST_WAIT;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
         end
         default: begin
            mem_tx_nxt_s.req_type = MEM_RD_NONE;
            mem_tx_nxt_s.addr     = 32'h0000_0000;
            state_nxt_s           = ST_IDLE;
         end
      endcase
      // Set has priority over clear.
      if (spur_set_s) begin
         spurious_nxt_s = 1'b1;
      end else if (spurious_clr) begin
         spurious_nxt_s = 1'b0;
      end else begin
         spurious_nxt_s = spurious_r;
      end
   end

   // State and registered outputs; reset drops any outstanding request silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r           <= ST_IDLE;
         mem_tx_r.req_type <= MEM_RD_NONE;
         mem_tx_r.addr     <= 32'h0000_0000;
         owner_r           <= REQ_INSTR;
         ptr_r             <= REQ_IMAGE;
         cnt_r             <= CNT_ZERO;
         done_r            <= 4'b0000;
         timeout_r         <= 4'b0000;
         spurious_r        <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         mem_tx_r   <= mem_tx_nxt_s;
         owner_r    <= owner_nxt_s;
         ptr_r      <= ptr_nxt_s;
         cnt_r      <= cnt_nxt_s;
         done_r     <= done_nxt_s;
         timeout_r  <= timeout_nxt_s;
         spurious_r <= spurious_nxt_s;
      end
   end

   assign mem_tx      = mem_tx_r;
   assign rsp_done    = done_r;
   assign rsp_timeout = timeout_r;
   assign spurious    = spurious_r;
   assign busy        = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

endmodule

// File: tb/tb_mem_rd_sched.sv
// Directed self-checking bench for mem_rd_sched with a scoreboard queue of
// expected grants, request words and response pulses.
module tb_mem_rd_sched;
   import mem_rd_sched_pkg::*;

   localparam int unsigned TO = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [3:0]          req_valid;
   logic [3:0][31:0]    req_addr;
   logic [3:0]          req_ready;
   logic [3:0]          rsp_done;
   logic [3:0]          rsp_timeout;
   t_mem_tx             mem_tx;
   t_mem_rx_status      mem_rx_status;
   logic                busy;
   logic                spurious;
   logic                spurious_clr;

   mem_rd_sched #(.TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .rsp_done      (rsp_done),
      .rsp_timeout   (rsp_timeout),
      .mem_tx        (mem_tx),
      .mem_rx_status (mem_rx_status),
      .busy          (busy),
      .spurious      (spurious),
      .spurious_clr  (spurious_clr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      string       tag;
      logic [63:0] exp;
   } sb_t;
   sb_t sb_q[$];

   t_mem_rd_req_type typ_tab [4] = '{MEM_RD_INSTR, MEM_RD_RNN_W, MEM_RD_DNN_W, MEM_RD_IMAGE};
   t_mem_rx_status   rx_tab  [4] = '{MEM_RX_INSTR_VALID, MEM_RX_RNN_W_VALID,
                                     MEM_RX_DNN_W_VALID, MEM_RX_IMAGE_VALID};
   logic [31:0]      addr_tab[4] = '{32'hA000_0000, 32'hA000_0010, 32'hA000_0020, 32'hA000_0030};
   int               order   [5] = '{0, 1, 2, 3, 0};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [63:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [63:0] obs);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_fail++;
         $error("FAIL sb_underflow: observed 0x%0h expected nothing", obs);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.exp);
      end
   endtask

   function automatic logic [63:0] tx_word(input t_mem_rd_req_type t, input logic [31:0] a);
      return {29'h0, t, a};
   endfunction

   function automatic logic [63:0] tx_of(input t_mem_tx m);
      return {29'h0, m};
   endfunction

   // Advance to 2 time units after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int idx;
      int waited;
      int prev_cyc;
      logic [3:0] oh;

      rst_n         = 1'b0;
      req_valid     = 4'b0000;
      req_addr      = '0;
      mem_rx_status = MEM_RX_NONE;
      spurious_clr  = 1'b0;
      prev_cyc      = 0;

      // ---- reset values ----
      repeat (3) @(posedge clk);
      #3;
      check("rst_ready",    req_ready,     64'h0);
      check("rst_done",     rsp_done,      64'h0);
      check("rst_timeout",  rsp_timeout,   64'h0);
      check("rst_busy",     busy,          64'h0);
      check("rst_spurious", spurious,      64'h0);
      check("rst_mem_tx",   tx_of(mem_tx), tx_word(MEM_RD_NONE, 32'h0));

      // ---- single INSTR request: c0 accept, c1 issue, status c4, done c5 ----
      next_cycle();
      rst_n       = 1'b1;
      req_valid   = 4'b0001;
      req_addr[0] = 32'h0000_1000;
      sb_push("s1_tx", tx_word(MEM_RD_INSTR, 32'h0000_1000));
      #1;
      check("s1_ready_c0", req_ready, 64'h1);
      next_cycle();
      req_valid = 4'b0000;
      #1;
      sb_check(tx_of(mem_tx));
      check("s1_busy_c1", busy, 64'h1);
      next_cycle(); #1;
      check("s1_tx_c2", tx_of(mem_tx), tx_word(MEM_RD_NONE, 32'h0));
      next_cycle(); #1;
      next_cycle();
      mem_rx_status = MEM_RX_INSTR_VALID;
      sb_push("s1_done", 64'h1);
      #1;
      check("s1_done_c4", rsp_done, 64'h0);
      next_cycle();
      mem_rx_status = MEM_RX_NONE;
      #1;
      sb_check(rsp_done);
      check("s1_idle_c5", busy, 64'h0);
      next_cycle(); #1;
      check("s1_done_c6", rsp_done, 64'h0);

      // ---- reset during WAIT: DNN outstanding, dropped without pulses ----
      next_cycle();
      req_valid   = 4'b0100;
      req_addr[2] = 32'h2000_0040;
      #1;
      check("mr_ready", req_ready, 64'h4);
      next_cycle(); req_valid = 4'b0000; #1;
      next_cycle(); #1;
      check("mr_busy_wait", busy, 64'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mr_busy_async",   busy,          64'h0);
      check("mr_tx_async",     tx_of(mem_tx), tx_word(MEM_RD_NONE, 32'h0));
      for (int i = 0; i < 2; i++) begin
         next_cycle(); #1;
         check("mr_no_done", rsp_done,    64'h0);
         check("mr_no_to",   rsp_timeout, 64'h0);
      end

      // ---- round-robin fairness after reset: order 0,1,2,3,0, period 4 ----
      next_cycle();
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_addr[i] = addr_tab[i];
      for (int k = 0; k < 5; k++) begin
         idx = order[k];
         oh  = 4'b0001 << idx;
         sb_push("rr_grant", {60'h0, oh});
         sb_push("rr_tx",    tx_word(typ_tab[idx], addr_tab[idx]));
         sb_push("rr_done",  {60'h0, oh});
      end
      #1;
      for (int k = 0; k < 5; k++) begin
         idx    = order[k];
         waited = 0;
         while (req_ready == 4'b0000 && waited < 8) begin
            next_cycle(); #1;
            waited++;
         end
         sb_check({60'h0, req_ready});
         if (k > 0) check("rr_period", 64'(cyc - prev_cyc), 64'd4);
         prev_cyc = cyc;
         next_cycle(); #1;
         sb_check(tx_of(mem_tx));
         next_cycle(); #1;
         next_cycle();
         mem_rx_status = rx_tab[idx];
         #1;
         next_cycle();
         mem_rx_status = MEM_RX_NONE;
         if (k == 4) req_valid = 4'b0000;
         #1;
         sb_check({60'h0, rsp_done});
      end
      check("rr_no_spurious", spurious, 64'h0);

      // ---- withdrawal: req_valid[2] pulsed while busy, never granted ----
      next_cycle();
      req_valid   = 4'b0001;
      req_addr[0] = 32'h0000_3000;
      #1;
      check("wd_ready_instr", req_ready, 64'h1);
      next_cycle();
      req_valid   = 4'b0100;
      req_addr[2] = 32'h2000_0080;
      #1;
      check("wd_ready_busy", req_ready, 64'h0);
      next_cycle(); req_valid = 4'b0000; #1;
      next_cycle(); mem_rx_status = MEM_RX_INSTR_VALID; #1;
      next_cycle(); mem_rx_status = MEM_RX_NONE; #1;
      check("wd_done",     rsp_done,  64'h1);
      check("wd_no_grant", req_ready, 64'h0);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); #1;
         check("wd_no_tx",   tx_of(mem_tx), tx_word(MEM_RD_NONE, 32'h0));
         check("wd_no_busy", busy,          64'h0);
      end

      // ---- timeout: DNN, no status, pulse 9 cycles after entering WAIT ----
      next_cycle();
      req_valid   = 4'b0100;
      req_addr[2] = 32'h2000_0100;
      sb_push("to_pulse", 64'h4);
      #1;
      check("to_ready", req_ready, 64'h4);
      next_cycle(); req_valid = 4'b0000; #1;
      next_cycle(); #1;
      for (int i = 1; i <= 8; i++) begin
         next_cycle(); #1;
         check("to_early", rsp_timeout, 64'h0);
      end
      check("to_busy_limit", busy, 64'h1);
      next_cycle(); #1;
      sb_check(rsp_timeout);
      check("to_no_done", rsp_done, 64'h0);
      check("to_idle",    busy,     64'h0);
      next_cycle(); #1;
      check("to_one_shot", rsp_timeout, 64'h0);

      // ---- timeout boundary: match with counter at the limit is done ----
      next_cycle();
      req_valid = 4'b0100;
      #1;
      check("tb_ready", req_ready, 64'h4);
      next_cycle(); req_valid = 4'b0000; #1;
      next_cycle(); #1;
      repeat (7) begin next_cycle(); #1; end
      next_cycle(); mem_rx_status = MEM_RX_DNN_W_VALID; #1;
      next_cycle(); mem_rx_status = MEM_RX_NONE; #1;
      check("tb_done",    rsp_done,    64'h4);
      check("tb_no_to",   rsp_timeout, 64'h0);

      // ---- spurious status while RNN outstanding ----
      next_cycle();
      req_valid   = 4'b0010;
      req_addr[1] = 32'h1000_0200;
      #1;
      check("sp_ready", req_ready, 64'h2);
      next_cycle(); req_valid = 4'b0000; #1;
      next_cycle(); #1;
      next_cycle(); mem_rx_status = MEM_RX_IMAGE_VALID; #1;
      next_cycle(); mem_rx_status = MEM_RX_NONE; #1;
      check("sp_set",       spurious, 64'h1);
      check("sp_stay_wait", busy,     64'h1);
      check("sp_no_done",   rsp_done, 64'h0);
      next_cycle(); mem_rx_status = MEM_RX_RNN_W_VALID; #1;
      next_cycle(); mem_rx_status = MEM_RX_NONE; #1;
      check("sp_done",   rsp_done, 64'h2);
      check("sp_sticky", spurious, 64'h1);
      next_cycle(); spurious_clr = 1'b1; #1;
      next_cycle(); spurious_clr = 1'b0; #1;
      check("sp_clr", spurious, 64'h0);
      // status in IDLE together with clear: set wins
      next_cycle(); mem_rx_status = MEM_RX_INSTR_VALID; spurious_clr = 1'b1; #1;
      next_cycle(); mem_rx_status = MEM_RX_NONE; spurious_clr = 1'b0; #1;
      check("sp_set_wins", spurious, 64'h1);
      check("sp_idle",     busy,     64'h0);
      next_cycle(); spurious_clr = 1'b1; #1;
      next_cycle(); spurious_clr = 1'b0; #1;
      check("sp_clr2", spurious, 64'h0);

      check("sb_empty", 64'(sb_q.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
